// File: rtl/mem_io_bridge_pkg.sv
// Shared IO map for the CPU memory bridge and firmware tests.
// IO offsets within the 4-word window and STATUS bit positions.
package mem_io_bridge_pkg;

  typedef enum logic [1:0] {
    IO_TX   = 2'd0,
    IO_STAT = 2'd1,
    IO_RX   = 2'd2,
    IO_LED  = 2'd3
  } io_off_e;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_RXV   = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_CNT   = 4;

endpackage

// File: rtl/mem_io_bridge_tx_fifo.sv
// TX FIFO: circular buffer with wrapping pointers and a count.
// Ports: push/push_data in, pop in, data (head), full, empty, count.
module io_tx_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign data    = mem[rd_ptr];
  assign pop_ok  = pop & ~empty;
  // When full, a same-cycle pop frees the slot being written.
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (push_ok & ~pop_ok)      count <= count + 1'b1;
      else if (pop_ok & ~push_ok) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/mem_io_bridge.sv
// Decodes CPU accesses into RAM or the 4-word IO window (TX FIFO,
// STATUS, RX latch, LED) and muxes read data back with RAM latency.
module mem_io_bridge
  import mem_io_bridge_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] IO_MEM = 16'hCFFD,
  parameter int TX_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] cpu_adr,
  input  logic [WIDTH-1:0] cpu_wdata,
  input  logic             cpu_we,
  output logic [WIDTH-1:0] cpu_rdata,
  output logic             ram_we,
  input  logic [WIDTH-1:0] ram_dout,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic [WIDTH-1:0] rx_data,
  input  logic             rx_strobe,
  output logic [WIDTH-1:0] led
);

  localparam int CW = $clog2(TX_DEPTH) + 1;
  localparam logic [WIDTH:0] IO_TOP =
    {1'b0, IO_MEM} + (WIDTH+1)'(3);

  logic             io_hit;
  io_off_e          off;
  logic             io_wr;
  logic             wr_q;
  logic             fire;
  logic             rd_sel_q;
  logic [WIDTH-1:0] io_rdata_q;
  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] status;
  logic [WIDTH-1:0] rx_latch;
  logic             rx_valid;
  logic             ovf;
  logic             ack;
  logic             ovf_clr;
  logic             push;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;

  assign io_hit = (cpu_adr >= IO_MEM) &&
                  ({1'b0, cpu_adr} <= IO_TOP);
  // Only the low bits of the offset matter inside the window.
  assign off    = io_off_e'(cpu_adr[1:0] - IO_MEM[1:0]);
  assign ram_we = cpu_we & ~io_hit;
  assign io_wr  = cpu_we & io_hit;
  // The CPU may hold we for several cycles; act once per store.
  assign fire   = io_wr & ~wr_q;

  assign push    = fire & (off == IO_TX);
  assign ovf_clr = fire & (off == IO_STAT) & cpu_wdata[ST_OVF];
  assign ack     = fire & (off == IO_RX);

  assign tx_valid  = ~empty;
  assign cpu_rdata = rd_sel_q ? io_rdata_q : ram_dout;

  io_tx_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(TX_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(cpu_wdata),
    .pop      (tx_ready),
    .data     (tx_data),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  always_comb begin
    status = '0;
    status[ST_CNT +: CW] = count;
    status[ST_OVF]   = ovf;
    status[ST_RXV]   = rx_valid;
    status[ST_EMPTY] = empty;
    status[ST_FULL]  = full;
  end

  always_comb begin
    rd_word = '0;
    unique case (off)
      IO_TX:   rd_word[CW-1:0] = count;
      IO_STAT: rd_word = status;
      IO_RX:   rd_word = rx_latch;
      IO_LED:  rd_word = led;
      default: rd_word = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_sel_q   <= 1'b0;
      io_rdata_q <= '0;
      wr_q       <= 1'b0;
      rx_latch   <= '0;
      rx_valid   <= 1'b0;
      ovf        <= 1'b0;
      led        <= '0;
    end else begin
      rd_sel_q   <= io_hit;
      io_rdata_q <= rd_word;
      wr_q       <= io_wr;
      if (fire && off == IO_LED) led <= cpu_wdata;
      // New RX data beats a same-cycle ack; an ack
      // alongside a strobe is not an overflow.
      if (rx_strobe) begin
        rx_latch <= rx_data;
        rx_valid <= 1'b1;
      end else if (ack) begin
        rx_valid <= 1'b0;
      end
      if (rx_strobe & rx_valid & ~ack) ovf <= 1'b1;
      else if (ovf_clr)                ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Bench for mem_io_bridge: queue-based model, per-cycle compare,
// directed scenarios with literal expectations, random traffic.
module tb_mem_io_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_adr;
  logic [15:0] cpu_wdata;
  logic        cpu_we;
  logic [15:0] cpu_rdata;
  logic        ram_we;
  logic [15:0] ram_dout;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] rx_data;
  logic        rx_strobe;
  logic [15:0] led;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  logic [15:0] m_q[$];
  logic [15:0] m_rx;
  logic [15:0] m_led;
  logic [15:0] m_prev_word;
  bit          m_rxv;
  bit          m_ovf;
  bit          m_prev_io;
  bit          m_prev_wr;

  always #5 clk = ~clk;

  mem_io_bridge dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_adr  (cpu_adr),
    .cpu_wdata(cpu_wdata),
    .cpu_we   (cpu_we),
    .cpu_rdata(cpu_rdata),
    .ram_we   (ram_we),
    .ram_dout (ram_dout),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_strobe(rx_strobe),
    .led      (led)
  );

  function automatic void chk(input string name,
                              input logic [15:0] act,
                              input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic bit in_win(input logic [15:0] a);
    return (a >= 16'hCFFD) && (a <= 16'hD000);
  endfunction

  function automatic logic [15:0] m_word(input logic [15:0] a);
    logic [15:0] rel;
    int n;
    rel = a - 16'hCFFD;
    n = m_q.size();
    case (rel[1:0])
      2'd0: return 16'(n);
      2'd1: return 16'(n * 16 + (m_ovf ? 8 : 0) + (m_rxv ? 4 : 0)
                    + (n == 0 ? 2 : 0) + (n == 4 ? 1 : 0));
      2'd2: return m_rx;
      default: return m_led;
    endcase
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_rx = 0; m_led = 0; m_prev_word = 0;
    m_rxv = 0; m_ovf = 0; m_prev_io = 0; m_prev_wr = 0;
  endtask

  task automatic model_tick();
    logic [15:0] rel;
    logic [15:0] w;
    bit hit, iow, fire, pop, full, old_rxv;
    hit  = in_win(cpu_adr);
    rel  = cpu_adr - 16'hCFFD;
    w    = m_word(cpu_adr);
    iow  = cpu_we && hit;
    fire = iow && !m_prev_wr;
    full = (m_q.size() == 4);
    pop  = (m_q.size() > 0) && tx_ready;
    old_rxv = m_rxv;
    if (pop) void'(m_q.pop_front());
    if (fire && rel[1:0] == 0 && (!full || pop))
      m_q.push_back(cpu_wdata);
    if (fire && rel[1:0] == 1 && cpu_wdata[3]) m_ovf = 0;
    if (fire && rel[1:0] == 2) m_rxv = 0;
    if (rx_strobe) begin
      if (old_rxv && !(fire && rel[1:0] == 2)) m_ovf = 1;
      m_rx  = rx_data;
      m_rxv = 1;
    end
    if (fire && rel[1:0] == 3) m_led = cpu_wdata;
    m_prev_io   = hit;
    m_prev_word = w;
    m_prev_wr   = iow;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cpu_rdata", cpu_rdata,
          m_prev_io ? m_prev_word : ram_dout);
      chk("ram_we", 16'(ram_we),
          16'(cpu_we && !in_win(cpu_adr)));
      chk("tx_valid", 16'(tx_valid), 16'(m_q.size() > 0));
      if (m_q.size() > 0) chk("tx_data", tx_data, m_q[0]);
      chk("led", led, m_led);
    end
  end

  task automatic step(input logic [15:0] a, input logic [15:0] d,
                      input logic we, input logic rdy,
                      input logic stb, input logic [15:0] rxd);
    cpu_adr   = a;
    cpu_wdata = d;
    cpu_we    = we;
    tx_ready  = rdy;
    rx_strobe = stb;
    rx_data   = rxd;
    ram_dout  = 16'($urandom);
    @(posedge clk);
    if (!reset) model_tick();
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(16'h0020, 16'h0, 1'b0, rdy, 1'b0, 16'h0);
  endtask

  task automatic push_word(input logic [15:0] w);
    step(16'hCFFD, w, 1'b1, 1'b0, 1'b0, 16'h0);
    idle(1'b0);
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] exp,
                    input string name);
    step(a, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    chk(name, cpu_rdata, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_clear();
    #1;
    chk("rst_tx_valid", 16'(tx_valid), 16'h0);
    chk("rst_led", led, 16'h0);
    chk("rst_rdata", cpu_rdata, ram_dout);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  logic [15:0] words [5];
  logic [15:0] ra;

  initial begin
    reset = 1'b1;
    cpu_adr = 0; cpu_wdata = 0; cpu_we = 0;
    tx_ready = 0; rx_strobe = 0; rx_data = 0;
    ram_dout = 16'h1234;
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("init_tx_valid", 16'(tx_valid), 16'h0);
    chk("init_led", led, 16'h0);
    chk("init_rdata", cpu_rdata, ram_dout);
    reset = 1'b0;
    chk_en = 1;

    // Held store: one push only.
    repeat (3) step(16'hCFFD, 16'hBEEF, 1'b1, 1'b0, 1'b0, 16'h0);
    rd(16'hCFFE, 16'h0010, "t2_status");
    chk("t2_head", tx_data, 16'hBEEF);
    idle(1'b1);
    chk("t2_drained", 16'(tx_valid), 16'h0);

    // Overfill then drain in order.
    for (int i = 0; i < 5; i++) begin
      words[i] = 16'h1100 + 16'(i);
      push_word(words[i]);
    end
    rd(16'hCFFE, 16'h0041, "t3_status");
    rd(16'hCFFD, 16'h0004, "t3_count");
    for (int i = 0; i < 4; i++) begin
      chk("t3_order", tx_data, words[i]);
      idle(1'b1);
    end
    chk("t3_empty", 16'(tx_valid), 16'h0);

    // Full FIFO: pop and push in the same cycle.
    for (int i = 0; i < 4; i++) push_word(16'h00A0 + 16'(i));
    step(16'hCFFD, 16'h00A4, 1'b1, 1'b1, 1'b0, 16'h0);
    idle(1'b0);
    rd(16'hCFFE, 16'h0041, "t4_status");
    for (int i = 1; i < 5; i++) begin
      chk("t4_order", tx_data, 16'h00A0 + 16'(i));
      idle(1'b1);
    end
    chk("t4_empty", 16'(tx_valid), 16'h0);

    // RX overrun, ovf clear, ack.
    step(16'h0020, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0001);
    step(16'h0020, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0002);
    rd(16'hCFFF, 16'h0002, "t5_rx");
    rd(16'hCFFE, 16'h000E, "t5_ovf_set");
    step(16'hCFFE, 16'h0008, 1'b1, 1'b0, 1'b0, 16'h0);
    idle(1'b0);
    rd(16'hCFFE, 16'h0006, "t5_ovf_clr");
    step(16'hCFFF, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0);
    idle(1'b0);
    rd(16'hCFFE, 16'h0002, "t5_ack");

    // LED write and read-back latency.
    step(16'hD000, 16'h00A5, 1'b1, 1'b0, 1'b0, 16'h0);
    rd(16'hD000, 16'h00A5, "t6_led");
    step(16'h0004, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("t6_ram", cpu_rdata, ram_dout);
    step(16'hCFFC, 16'h7777, 1'b1, 1'b0, 1'b0, 16'h0);
    chk("below_win_we", 16'(ram_we), 16'h1);

    // Reset mid-burst with 3 queued words.
    for (int i = 0; i < 3; i++) push_word(16'h0B00 + 16'(i));
    step(16'hCFFE, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    do_reset();
    step(16'h0010, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("t1_ram", cpu_rdata, ram_dout);
    rd(16'hCFFE, 16'h0002, "t1_status");

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      case ($urandom_range(0, 3))
        0: ra = 16'($urandom_range(0, 255));
        1: ra = ($urandom_range(0, 1) != 0) ? 16'hCFFC : 16'hD001;
        default: ra = 16'hCFFD + 16'($urandom_range(0, 3));
      endcase
      step(ra, 16'($urandom), $urandom_range(0, 2) != 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 6) == 0,
           16'($urandom));
    end

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
